// File: rtl/cr_clic_arb_pipe_pkg.sv
// Shared sizing constants for the pipelined CLIC arbiter.
// The CLIC_ARB_HV_TIEBREAK_EN macro is consumed in cr_clic_arb_cmp_tree.
package cr_clic_arb_pipe_pkg;

    localparam int CLIC_INTNUM     = 64;
    localparam int CLIC_INTCTLBITS = 3;
    localparam int CLIC_ARB_NGRP   = 8;
    localparam int CLIC_ARB_IDW    = 12;

    // Arbitration key is {mode, level[ctlBits-1:0]}.
    function automatic int clicKeyW(int ctlBits);
        return ctlBits + 1;
    endfunction

    localparam int CLIC_ARB_KEYW = clicKeyW(CLIC_INTCTLBITS);

endpackage

// File: rtl/cr_clic_arb_cmp_tree.sv
// Combinational balanced max-tree selecting the best {vld, key, id, hv} entry.
// Define CLIC_ARB_HV_TIEBREAK_EN to let hv=1 win equal-key ties before id is considered.
module cr_clic_arb_cmp_tree
    import cr_clic_arb_pipe_pkg::*;
#(
    parameter int KEYW = CLIC_ARB_KEYW,
    parameter int N    = CLIC_ARB_NGRP,
    parameter int IDW  = CLIC_ARB_IDW
)(
    input  logic [N-1:0]      vld_i,
    input  logic [N*KEYW-1:0] key_i,
    input  logic [N*IDW-1:0]  id_i,
    input  logic [N-1:0]      hv_i,
    output logic              vld_o,
    output logic [KEYW-1:0]   key_o,
    output logic [IDW-1:0]    id_o,
    output logic              hv_o
);

    localparam int LVLS = (N > 1) ? $clog2(N) : 0;
    localparam int NP   = 1 << LVLS;
    localparam int KPW  = NP * KEYW;
    localparam int IPW  = NP * IDW;

    logic [NP-1:0]   vldPad;
    logic [NP-1:0]   hvPad;
    logic [KPW-1:0]  keyPad;
    logic [IPW-1:0]  idPad;

    logic            nv  [NP];
    logic [KEYW-1:0] nk  [NP];
    logic [IDW-1:0]  nid [NP];
    logic            nh  [NP];

    assign vldPad = NP'(vld_i);
    assign hvPad  = NP'(hv_i);
    assign keyPad = KPW'(key_i);
    assign idPad  = IPW'(id_i);

    function automatic logic aWins(
        input logic            av,
        input logic [KEYW-1:0] ak,
        input logic [IDW-1:0]  aid,
        input logic            ah,
        input logic            bv,
        input logic [KEYW-1:0] bk,
        input logic [IDW-1:0]  bid,
        input logic            bh
    );
        if (!av) return 1'b0;
        if (!bv) return 1'b1;
        if (ak != bk) return ak > bk;
`ifdef CLIC_ARB_HV_TIEBREAK_EN
        if (ah != bh) return ah;
`else
        if (ah != bh) return aid < bid;
`endif
        return aid < bid;
    endfunction

    // Reduce in place: node i at each level takes the better of nodes 2i and 2i+1.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            nv[i]  = vldPad[i];
            nk[i]  = keyPad[i*KEYW +: KEYW];
            nid[i] = idPad[i*IDW +: IDW];
            nh[i]  = hvPad[i];
        end
        for (int l = 0; l < LVLS; l++) begin
            for (int i = 0; i < NP/2; i++) begin
                if (i < (NP >> (l + 1))) begin
                    if (aWins(nv[2*i], nk[2*i], nid[2*i], nh[2*i],
                              nv[2*i+1], nk[2*i+1], nid[2*i+1], nh[2*i+1])) begin
                        nv[i]  = nv[2*i];
                        nk[i]  = nk[2*i];
                        nid[i] = nid[2*i];
                        nh[i]  = nh[2*i];
                    end else begin
                        nv[i]  = nv[2*i+1];
                        nk[i]  = nk[2*i+1];
                        nid[i] = nid[2*i+1];
                        nh[i]  = nh[2*i+1];
                    end
                end
            end
        end
    end

    assign vld_o = nv[0];
    assign key_o = nk[0];
    assign id_o  = nid[0];
    assign hv_o  = nh[0];

endmodule

// File: rtl/cr_clic_arb_pipe.sv
// Two-stage pipelined CLIC arbiter: registered group winners, then a registered final winner.
// Tie-break behaviour follows CLIC_ARB_HV_TIEBREAK_EN (see cr_clic_arb_cmp_tree).
module cr_clic_arb_pipe
    import cr_clic_arb_pipe_pkg::*;
#(
    parameter int CLICINTNUM     = CLIC_INTNUM,
    parameter int CLICINTCTLBITS = CLIC_INTCTLBITS,
    parameter int NGRP           = CLIC_ARB_NGRP,
    parameter int ID_WIDTH       = CLIC_ARB_IDW
)(
    input  logic                                   out_clk,
    input  logic                                   cpurst_b,
    input  logic [CLICINTNUM-1:0]                  kid_arb_int_req,
    input  logic [CLICINTNUM-1:0]                  kid_arb_int_hv,
    input  logic [(CLICINTCTLBITS+1)*CLICINTNUM-1:0] kid_arb_int_all_vec,
    input  logic [CLICINTCTLBITS-1:0]              ctrl_xx_int_lv_or_mask,
    input  logic [7:0]                             ctrl_arb_int_th,
    input  logic                                   ctrl_arb_int_claim,
    output logic                                   arb_ctrl_int_vld,
    output logic [ID_WIDTH-1:0]                    arb_ctrl_int_id,
    output logic [7:0]                             arb_ctrl_int_il,
    output logic                                   arb_ctrl_int_mode,
    output logic                                   arb_ctrl_int_hv,
    output logic                                   out_clk_en
);

    localparam int CTL  = CLICINTCTLBITS;
    localparam int KEYW = clicKeyW(CTL);
    localparam int GSZ  = CLICINTNUM / NGRP;

    logic [NGRP-1:0]          c1Vld;
    logic [NGRP*KEYW-1:0]     c1Key;
    logic [NGRP*ID_WIDTH-1:0] c1Id;
    logic [NGRP-1:0]          c1Hv;

    logic [NGRP-1:0]          gVld_q, gVld_d;
    logic [NGRP*KEYW-1:0]     gKey_q, gKey_d;
    logic [NGRP*ID_WIDTH-1:0] gId_q,  gId_d;
    logic [NGRP-1:0]          gHv_q,  gHv_d;

    logic                     c2Vld;
    logic [KEYW-1:0]          c2Key;
    logic [ID_WIDTH-1:0]      c2Id;
    logic                     c2Hv;

    logic                     s2Vld_q, s2Vld_d;
    logic [KEYW-1:0]          s2Key_q;
    logic [ID_WIDTH-1:0]      s2Id_q;
    logic                     s2Hv_q;

    logic [CTL-1:0]           s2Lvl;
    logic [7:0]               ilRaw;
    logic                     flush;

    genvar g, j;
    generate
        for (g = 0; g < NGRP; g++) begin : gen_grp
            logic [GSZ*ID_WIDTH-1:0] grpId;
            for (j = 0; j < GSZ; j++) begin : gen_id
                assign grpId[j*ID_WIDTH +: ID_WIDTH] = ID_WIDTH'(g*GSZ + j);
            end
            cr_clic_arb_cmp_tree #(.KEYW(KEYW), .N(GSZ), .IDW(ID_WIDTH)) u_grp_tree (
                .vld_i (kid_arb_int_req[g*GSZ +: GSZ]),
                .key_i (kid_arb_int_all_vec[g*GSZ*KEYW +: GSZ*KEYW]),
                .id_i  (grpId),
                .hv_i  (kid_arb_int_hv[g*GSZ +: GSZ]),
                .vld_o (c1Vld[g]),
                .key_o (c1Key[g*KEYW +: KEYW]),
                .id_o  (c1Id[g*ID_WIDTH +: ID_WIDTH]),
                .hv_o  (c1Hv[g])
            );
        end
    endgenerate

    cr_clic_arb_cmp_tree #(.KEYW(KEYW), .N(NGRP), .IDW(ID_WIDTH)) u_fin_tree (
        .vld_i (gVld_q),
        .key_i (gKey_q),
        .id_i  (gId_q),
        .hv_i  (gHv_q),
        .vld_o (c2Vld),
        .key_o (c2Key),
        .id_o  (c2Id),
        .hv_o  (c2Hv)
    );

    // A claim of the presented winner empties both stages; refill comes from live req.
    assign flush = ctrl_arb_int_claim & arb_ctrl_int_vld;

    always_comb begin
        gVld_d  = flush ? '0 : c1Vld;
        gKey_d  = c1Key;
        gId_d   = c1Id;
        gHv_d   = c1Hv;
        s2Vld_d = flush ? 1'b0 : c2Vld;
    end

    always_ff @(posedge out_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            gVld_q  <= '0;
            gKey_q  <= '0;
            gId_q   <= '0;
            gHv_q   <= '0;
            s2Vld_q <= 1'b0;
            s2Key_q <= '0;
            s2Id_q  <= '0;
            s2Hv_q  <= 1'b0;
        end else begin
            gVld_q  <= gVld_d;
            gKey_q  <= gKey_d;
            gId_q   <= gId_d;
            gHv_q   <= gHv_d;
            s2Vld_q <= s2Vld_d;
            s2Key_q <= c2Key;
            s2Id_q  <= c2Id;
            s2Hv_q  <= c2Hv;
        end
    end

    assign s2Lvl = s2Key_q[CTL-1:0];

    generate
        if (CTL == 8) begin : gen_il_full
            assign ilRaw = s2Lvl | (ctrl_xx_int_lv_or_mask & {CTL{s2Vld_q}});
        end else begin : gen_il_pad
            assign ilRaw = {s2Lvl | (ctrl_xx_int_lv_or_mask & {CTL{s2Vld_q}}), {(8-CTL){s2Vld_q}}};
        end
    endgenerate

    // Threshold compare stays combinational so mth updates are seen immediately.
    assign arb_ctrl_int_vld  = s2Vld_q & (ilRaw > ctrl_arb_int_th);
    assign arb_ctrl_int_id   = arb_ctrl_int_vld ? s2Id_q : '0;
    assign arb_ctrl_int_il   = arb_ctrl_int_vld ? ilRaw : 8'h00;
    assign arb_ctrl_int_mode = arb_ctrl_int_vld & s2Key_q[CTL];
    assign arb_ctrl_int_hv   = arb_ctrl_int_vld & s2Hv_q;

    assign out_clk_en = (|kid_arb_int_req) | (|gVld_q) | s2Vld_q | ctrl_arb_int_claim;

endmodule

// File: tb/tb_cr_clic_arb_pipe.sv
// Directed, table-driven bench for cr_clic_arb_pipe (default 64 sources, 3 level bits, 8 groups).
// Expectations for the hv tie case follow CLIC_ARB_HV_TIEBREAK_EN.
module tb_cr_clic_arb_pipe;

    logic         out_clk;
    logic         cpurst_b;
    logic [63:0]  req;
    logic [63:0]  hv;
    logic [255:0] allVec;
    logic [2:0]   mask;
    logic [7:0]   th;
    logic         claim;
    logic         vld;
    logic [11:0]  id;
    logic [7:0]   il;
    logic         mode;
    logic         hvOut;
    logic         clkEn;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        string        name;
        logic [63:0]  req;
        logic [63:0]  hv;
        logic [255:0] allVec;
        logic [2:0]   mask;
        logic [7:0]   th;
        logic         eVld;
        logic [11:0]  eId;
        logic [7:0]   eIl;
        logic         eMode;
        logic         eHv;
    } vecT;

    vecT vecs[$];

    cr_clic_arb_pipe dut (
        .out_clk                (out_clk),
        .cpurst_b               (cpurst_b),
        .kid_arb_int_req        (req),
        .kid_arb_int_hv         (hv),
        .kid_arb_int_all_vec    (allVec),
        .ctrl_xx_int_lv_or_mask (mask),
        .ctrl_arb_int_th        (th),
        .ctrl_arb_int_claim     (claim),
        .arb_ctrl_int_vld       (vld),
        .arb_ctrl_int_id        (id),
        .arb_ctrl_int_il        (il),
        .arb_ctrl_int_mode      (mode),
        .arb_ctrl_int_hv        (hvOut),
        .out_clk_en             (clkEn)
    );

    initial out_clk = 1'b0;
    always #5 out_clk = ~out_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [255:0] putKey(input logic [255:0] v, input int idx, input logic [3:0] key);
        logic [255:0] r;
        r = v;
        r[idx*4 +: 4] = key;
        return r;
    endfunction

    function automatic logic [63:0] bit64(input int idx);
        logic [63:0] r;
        r = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge out_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp)
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        else
            passCount++;
    endtask

    task automatic checkAll(input string name, input logic eVld, input logic [11:0] eId,
                            input logic [7:0] eIl, input logic eMode, input logic eHv);
        checkOutput({name, ".vld"},  32'(vld),   32'(eVld));
        checkOutput({name, ".id"},   32'(id),    32'(eId));
        checkOutput({name, ".il"},   32'(il),    32'(eIl));
        checkOutput({name, ".mode"}, 32'(mode),  32'(eMode));
        checkOutput({name, ".hv"},   32'(hvOut), 32'(eHv));
    endtask

    task automatic addVec(input string name, input logic [63:0] r, input logic [63:0] h,
                          input logic [255:0] a, input logic [2:0] m, input logic [7:0] t,
                          input logic eV, input logic [11:0] eI, input logic [7:0] eL,
                          input logic eM, input logic eH);
        vecT v;
        v.name = name; v.req = r; v.hv = h; v.allVec = a; v.mask = m; v.th = t;
        v.eVld = eV; v.eId = eI; v.eIl = eL; v.eMode = eM; v.eHv = eH;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic [63:0] r, input logic [63:0] h,
                                 input logic [255:0] a, input logic [2:0] m, input logic [7:0] t);
        req = r; hv = h; allVec = a; mask = m; th = t;
    endtask

    initial begin
        logic         tieHv;
        logic [11:0]  tieId;
`ifdef CLIC_ARB_HV_TIEBREAK_EN
        tieHv = 1'b1; tieId = 12'd40;
`else
        tieHv = 1'b0; tieId = 12'd9;
`endif
        addVec("idle", '0, '0, '0, 3'b000, 8'h00, 0, 12'd0, 8'h00, 0, 0);
        addVec("single5", bit64(5), '0, putKey('0, 5, 4'b0010), 3'b000, 8'h00, 1, 12'd5, 8'h5F, 0, 0);
        addVec("tieLowId", bit64(9) | bit64(40), '0,
               putKey(putKey(putKey('0, 9, 4'b0110), 40, 4'b0110), 50, 4'b1111),
               3'b000, 8'h00, 1, 12'd9, 8'hDF, 0, 0);
        addVec("tieHv", bit64(9) | bit64(40), bit64(40),
               putKey(putKey('0, 9, 4'b0110), 40, 4'b0110), 3'b000, 8'h00, 1, tieId, 8'hDF, 0, tieHv);
        addVec("modeDom", bit64(3) | bit64(60), '0,
               putKey(putKey('0, 3, 4'b0111), 60, 4'b1001), 3'b000, 8'h00, 1, 12'd60, 8'h3F, 1, 0);
        addVec("thEqual", bit64(7), '0, putKey('0, 7, 4'b0010), 3'b000, 8'h5F, 0, 12'd0, 8'h00, 0, 0);
        addVec("thBelow", bit64(7), '0, putKey('0, 7, 4'b0010), 3'b000, 8'h5E, 1, 12'd7, 8'h5F, 0, 0);
        addVec("orMask", bit64(20), '0, putKey('0, 20, 4'b0000), 3'b101, 8'h00, 1, 12'd20, 8'hBF, 0, 0);
        addVec("sameGrp", bit64(16) | bit64(17), '0,
               putKey(putKey('0, 16, 4'b0011), 17, 4'b0011), 3'b000, 8'h00, 1, 12'd16, 8'h7F, 0, 0);
        addVec("edgeIds", bit64(0) | bit64(63), '0,
               putKey(putKey('0, 0, 4'b1111), 63, 4'b1111), 3'b000, 8'hFE, 1, 12'd0, 8'hFF, 1, 0);
        addVec("thMax", bit64(63), '0, putKey('0, 63, 4'b1111), 3'b000, 8'hFF, 0, 12'd0, 8'h00, 0, 0);
        addVec("hvOut", bit64(33), bit64(33), putKey('0, 33, 4'b0100), 3'b000, 8'h00, 1, 12'd33, 8'h9F, 0, 1);

        cpurst_b = 1'b0;
        claim = 1'b0;
        applyStimulus('0, '0, '0, 3'b000, 8'h00);
        tick();
        checkAll("reset", 0, 12'd0, 8'h00, 0, 0);
        checkOutput("reset.clkEn", 32'(clkEn), 32'd0);
        #2 cpurst_b = 1'b1;
        tick();

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].req, vecs[k].hv, vecs[k].allVec, vecs[k].mask, vecs[k].th);
            tick();
            tick();
            checkAll(vecs[k].name, vecs[k].eVld, vecs[k].eId, vecs[k].eIl, vecs[k].eMode, vecs[k].eHv);
        end

        // Two-edge latency on rise and on drop.
        applyStimulus('0, '0, '0, 3'b000, 8'h00);
        tick(); tick(); tick();
        applyStimulus(bit64(5), '0, putKey('0, 5, 4'b0010), 3'b000, 8'h00);
        tick();
        checkOutput("lat.edge1.vld", 32'(vld), 32'd0);
        tick();
        checkAll("lat.edge2", 1, 12'd5, 8'h5F, 0, 0);
        req = '0;
        tick();
        checkOutput("drop.edge1.vld", 32'(vld), 32'd1);
        tick();
        checkOutput("drop.edge2.vld", 32'(vld), 32'd0);

        // Threshold acts without a clock edge.
        applyStimulus(bit64(7), '0, putKey('0, 7, 4'b0010), 3'b000, 8'h00);
        tick(); tick();
        #2 th = 8'h5F;
        #1 checkOutput("thComb.hold.vld", 32'(vld), 32'd0);
        th = 8'h5E;
        #1 checkOutput("thComb.pass.vld", 32'(vld), 32'd1);
        tick();

        // Claim flush with the winner dropped and a new source pending.
        applyStimulus(bit64(12), '0, putKey(putKey('0, 12, 4'b0010), 13, 4'b0010), 3'b000, 8'h00);
        tick(); tick();
        checkAll("claim.pre", 1, 12'd12, 8'h5F, 0, 0);
        req = bit64(13);
        claim = 1'b1;
        tick();
        claim = 1'b0;
        checkOutput("claim.flush.vld", 32'(vld), 32'd0);
        tick();
        checkOutput("claim.refill1.vld", 32'(vld), 32'd0);
        tick();
        checkAll("claim.refill2", 1, 12'd13, 8'h5F, 0, 0);

        // Claim while nothing is presented must not disturb the filling pipeline.
        req = '0;
        tick(); tick(); tick();
        applyStimulus(bit64(14), '0, putKey('0, 14, 4'b0010), 3'b000, 8'h00);
        claim = 1'b1;
        tick();
        claim = 1'b0;
        tick();
        checkAll("claimIgnored", 1, 12'd14, 8'h5F, 0, 0);

        // Clock enable stays on while pipeline state is still live.
        req = '0;
        #1 checkOutput("clkEn.pipeLive", 32'(clkEn), 32'd1);
        req = bit64(14);
        tick(); tick();
        checkOutput("preReset.vld", 32'(vld), 32'd1);

        // Asynchronous reset mid-arbitration.
        #2 cpurst_b = 1'b0;
        #1 checkAll("asyncReset", 0, 12'd0, 8'h00, 0, 0);
        checkOutput("asyncReset.clkEnReq", 32'(clkEn), 32'd1);
        req = '0;
        #1 checkOutput("asyncReset.clkEnIdle", 32'(clkEn), 32'd0);
        tick();
        #2 cpurst_b = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
